// File: rtl/issue_buffer.sv
// Dual-slot instruction issue buffer between fetch and decode: circular queue of {inst, pc}.
// Dual issue is compiled in only when IB_DUAL_ISSUE_EN is defined; otherwise one entry issues per cycle.
module issue_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          stall_i,
    input  logic          fetch_valid1_i,
    input  logic          fetch_valid2_i,
    input  logic [31:0]   fetch_inst1_i,
    input  logic [31:0]   fetch_inst2_i,
    input  logic [31:0]   fetch_pc_i,
    output logic          full_o,
    output logic [31:0]   inst1_o,
    output logic [31:0]   inst2_o,
    output logic [31:0]   pc1_o,
    output logic [31:0]   pc2_o,
    output logic          valid1_o,
    output logic          issue_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE        = (AW+1)'(1);
    localparam logic [AW:0] TWO        = (AW+1)'(2);

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;

    // Branches and jumps: these need their delay slot buffered before they may issue.
    function automatic logic is_cti(input logic [31:0] i);
        is_cti = 1'b0;
        case (i[31:26])
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_cti = 1'b1;
            OP_REGIMM:  is_cti = (i[20:16] == 5'h00) || (i[20:16] == 5'h01) ||
                                 (i[20:16] == 5'h10) || (i[20:16] == 5'h11);
            OP_SPECIAL: is_cti = (i[5:0] == 6'h08) || (i[5:0] == 6'h09);
            default:    is_cti = 1'b0;
        endcase
    endfunction

    // NOTE: storage has no reset; head/tail/count alone define which entries are live.
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] tail_p1;
    logic [AW:0]   count;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    logic [31:0]   head_inst;
    logic          valid1;
    logic          dual;

    assign head_inst = inst_mem[head];
    assign tail_p1   = tail + AW'(1);
    assign full_o    = count >= FULL_LEVEL;
    assign count_o   = count;

    assign valid1 = (count != '0) && !(is_cti(head_inst) && (count == ONE));

`ifdef IB_DUAL_ISSUE_EN
    localparam logic [5:0] OP_COP0     = 6'h10;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

    function automatic logic [4:0] dest_reg(input logic [31:0] i);
        dest_reg = 5'd0;
        case (i[31:26])
            OP_SPECIAL:  dest_reg = i[15:11];
            OP_SPECIAL2: if (i[5:0] == 6'h02) dest_reg = i[15:11];
            OP_JAL:      dest_reg = 5'd31;
            OP_REGIMM:   if ((i[20:16] == 5'h10) || (i[20:16] == 5'h11)) dest_reg = 5'd31;
            OP_COP0:     if (i[25:21] == 5'h00) dest_reg = i[20:16];
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h30:
                         dest_reg = i[20:16];
            default:     dest_reg = 5'd0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        is_store = (op == 6'h28) || (op == 6'h29) || (op == 6'h2A) ||
                   (op == 6'h2B) || (op == 6'h2E);
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        is_mem = ((op >= 6'h20) && (op <= 6'h26)) || is_store(op) ||
                 (op == 6'h30) || (op == 6'h38);
    endfunction

    // Pairing rules: RAW between the two slots, and instructions that must issue alone.
    function automatic logic pair_blocked(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] d;
        logic       rt_used;
        logic       raw;
        logic       b_solo;
        logic       a_solo;
        d       = dest_reg(a);
        rt_used = (b[31:26] == OP_SPECIAL) || is_store(b[31:26]) ||
                  (b[31:26] == OP_BEQ) || (b[31:26] == OP_BNE);
        raw     = (d != 5'd0) && ((b[25:21] == d) || (rt_used && (b[20:16] == d)));
        b_solo  = is_cti(b) || is_mem(b[31:26]) ||
                  ((b[31:26] == OP_SPECIAL) && (b[5:0] >= 6'h10) && (b[5:0] <= 6'h1B)) ||
                  (b[31:26] == OP_SPECIAL2) || (b[31:26] == OP_COP0);
        a_solo  = (a[31:26] == OP_COP0) ||
                  ((a[31:26] == OP_SPECIAL) && ((a[5:0] == 6'h0C) || (a[5:0] == 6'h0D)));
        pair_blocked = raw || b_solo || a_solo;
    endfunction

    logic [AW-1:0] head_p1;
    assign head_p1 = head + AW'(1);
    assign dual    = valid1 && (count >= TWO) && !pair_blocked(head_inst, inst_mem[head_p1]);
    assign inst2_o = dual ? inst_mem[head_p1] : '0;
    assign pc2_o   = dual ? pc_mem[head_p1]   : '0;
`else
    assign dual    = 1'b0;
    assign inst2_o = '0;
    assign pc2_o   = '0;
`endif

    assign valid1_o = valid1;
    assign issue_o  = dual;
    assign inst1_o  = valid1 ? head_inst    : '0;
    assign pc1_o    = valid1 ? pc_mem[head] : '0;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        push_n = 2'd0;
        pop_n  = 2'd0;
        if (!full_o && !flush_i && fetch_valid1_i)
            push_n = fetch_valid2_i ? 2'd2 : 2'd1;
        if (valid1 && !stall_i && !flush_i)
            pop_n = dual ? 2'd2 : 2'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count + (AW+1)'(push_n) - (AW+1)'(pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (push_n != 2'd0)) begin
            inst_mem[tail] <= fetch_inst1_i;
            pc_mem[tail]   <= fetch_pc_i;
            if (push_n == 2'd2) begin
                inst_mem[tail_p1] <= fetch_inst2_i;
                pc_mem[tail_p1]   <= fetch_pc_i + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_issue_buffer.sv
// Self-checking bench for issue_buffer: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_issue_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef IB_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    localparam logic [31:0] ADDU_A = 32'h0043_0821;  // addu $1,$2,$3
    localparam logic [31:0] ADDU_B = 32'h00A6_2021;  // addu $4,$5,$6
    localparam logic [31:0] ADDIU1 = 32'h2401_0005;  // addiu $1,$0,5
    localparam logic [31:0] ADDU_C = 32'h0021_1021;  // addu $2,$1,$1
    localparam logic [31:0] BEQ0   = 32'h1000_0004;  // beq $0,$0,+4
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, flush_i, stall_i, fetch_valid1_i, fetch_valid2_i;
    logic [31:0] fetch_inst1_i, fetch_inst2_i, fetch_pc_i;
    logic        full_o, valid1_o, issue_o;
    logic [31:0] inst1_o, inst2_o, pc1_o, pc2_o;
    logic [AW:0] count_o;

    always #5 clk = ~clk;

    issue_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
        .fetch_valid1_i(fetch_valid1_i), .fetch_valid2_i(fetch_valid2_i),
        .fetch_inst1_i(fetch_inst1_i), .fetch_inst2_i(fetch_inst2_i), .fetch_pc_i(fetch_pc_i),
        .full_o(full_o), .inst1_o(inst1_o), .inst2_o(inst2_o), .pc1_o(pc1_o), .pc2_o(pc2_o),
        .valid1_o(valid1_o), .issue_o(issue_o), .count_o(count_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] inst; logic [31:0] pc; } ent_t;
    ent_t mq[$];
    ent_t pend_push[$];
    int   pend_pop;
    bit   pend_clear;

    function automatic bit tb_is_cti(input logic [31:0] w);
        logic [5:0] op, fn;
        logic [4:0] rt;
        op = w[31:26]; rt = w[20:16]; fn = w[5:0];
        if (op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07}) return 1'b1;
        if (op == 6'h01 && (rt inside {5'h00, 5'h01, 5'h10, 5'h11})) return 1'b1;
        if (op == 6'h00 && (fn inside {6'h08, 6'h09})) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int tb_dest(input logic [31:0] w);
        int op, rs, rt, rd, fn;
        op = int'(w[31:26]); rs = int'(w[25:21]); rt = int'(w[20:16]);
        rd = int'(w[15:11]); fn = int'(w[5:0]);
        if (op == 0) return rd;
        if (op == 'h1C) return (fn == 2) ? rd : 0;
        if (op == 3) return 31;
        if (op == 1) return (rt == 'h10 || rt == 'h11) ? 31 : 0;
        if (op >= 'h08 && op <= 'h0F) return rt;
        if ((op >= 'h20 && op <= 'h26) || op == 'h30) return rt;
        if (op == 'h10) return (rs == 0) ? rt : 0;
        return 0;
    endfunction

    function automatic bit tb_blocked(input logic [31:0] a, input logic [31:0] b);
        int d, bop, bfn, aop, afn;
        bit rt_used;
        d   = tb_dest(a);
        aop = int'(a[31:26]); afn = int'(a[5:0]);
        bop = int'(b[31:26]); bfn = int'(b[5:0]);
        rt_used = (bop == 0) || (bop inside {'h28, 'h29, 'h2A, 'h2B, 'h2E, 'h04, 'h05});
        if (d != 0 && (int'(b[25:21]) == d || (rt_used && int'(b[20:16]) == d))) return 1'b1;
        if (tb_is_cti(b)) return 1'b1;
        if ((bop >= 'h20 && bop <= 'h26) || (bop >= 'h28 && bop <= 'h2B) ||
            bop == 'h2E || bop == 'h30 || bop == 'h38) return 1'b1;
        if (bop == 0 && bfn >= 'h10 && bfn <= 'h1B) return 1'b1;
        if (bop == 'h1C || bop == 'h10) return 1'b1;
        if (aop == 'h10) return 1'b1;
        if (aop == 0 && (afn == 'h0C || afn == 'h0D)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic r, input logic v1, input logic v2, input logic [31:0] i1,
                         input logic [31:0] i2, input logic [31:0] pc, input logic st,
                         input logic fl);
        rst = r; fetch_valid1_i = v1; fetch_valid2_i = v2;
        fetch_inst1_i = i1; fetch_inst2_i = i2; fetch_pc_i = pc;
        stall_i = st; flush_i = fl;
    endtask

    // Compares DUT outputs with the model mid-cycle and works out the model's next state.
    task automatic sample();
        int   n;
        bit   e_full, e_v1, e_iss;
        ent_t e0, e1;
        @(negedge clk);
        n  = mq.size();
        e0 = '0; e1 = '0;
        if (n >= 1) e0 = mq[0];
        if (n >= 2) e1 = mq[1];
        e_full = (DEPTH - n) < 2;
        e_v1   = (n >= 1) && !(tb_is_cti(e0.inst) && n == 1);
        e_iss  = DUAL && e_v1 && (n >= 2) && !tb_blocked(e0.inst, e1.inst);
        check("count",  count_o,  n);
        check("full",   full_o,   e_full);
        check("valid1", valid1_o, e_v1);
        check("issue",  issue_o,  e_iss);
        check("inst1",  inst1_o,  e_v1  ? e0.inst : 32'h0);
        check("pc1",    pc1_o,    e_v1  ? e0.pc   : 32'h0);
        check("inst2",  inst2_o,  e_iss ? e1.inst : 32'h0);
        check("pc2",    pc2_o,    e_iss ? e1.pc   : 32'h0);
        pend_clear = rst || flush_i;
        pend_pop   = (stall_i || flush_i || !e_v1) ? 0 : (e_iss ? 2 : 1);
        pend_push.delete();
        if (!e_full && !flush_i && fetch_valid1_i) begin
            pend_push.push_back('{inst: fetch_inst1_i, pc: fetch_pc_i});
            if (fetch_valid2_i)
                pend_push.push_back('{inst: fetch_inst2_i, pc: fetch_pc_i + 32'd4});
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (pend_clear) begin
            mq.delete();
        end else begin
            for (int k = 0; k < pend_pop; k++) void'(mq.pop_front());
            foreach (pend_push[k]) mq.push_back(pend_push[k]);
        end
    endtask

    task automatic step(input logic r, input logic v1, input logic v2, input logic [31:0] i1,
                        input logic [31:0] i2, input logic [31:0] pc, input logic st,
                        input logic fl);
        drive(r, v1, v2, i1, i2, pc, st, fl);
        sample();
        advance();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] w;
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        imm = 16'($urandom());
        case ($urandom_range(0, 16))
            0, 15:   w = {6'h00, rs, rt, rd, 5'h00, 6'h21};
            1, 16:   w = {6'h09, rs, rt, imm};
            2:       w = {6'h23, rs, rt, imm};
            3:       w = {6'h2B, rs, rt, imm};
            4:       w = {6'h04, rs, rt, imm};
            5:       w = {6'h02, 26'($urandom())};
            6:       w = {6'h03, 26'($urandom())};
            7:       w = {6'h00, rs, 15'h0, 6'h08};
            8:       w = {6'h00, 10'h0, rd, 5'h00, 6'h10};
            9:       w = {6'h1C, rs, rt, rd, 5'h00, 6'h02};
            10:      w = {6'h10, 5'h00, rt, rd, 11'h0};
            11:      w = 32'h4200_0018;
            12:      w = 32'h0000_000C;
            13:      w = {6'h01, rs, 5'h10, imm};
            default: w = NOP;
        endcase
        return w;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v1, v2;
        logic [31:0] i1, i2, pc;
        logic        stall, flush;
        logic        e_v1, e_iss, e_full;
        logic [AW:0] e_cnt;
        logic [31:0] e_pc2;
    } vec_t;

    function automatic vec_t mk(input logic v1, input logic v2, input logic [31:0] i1,
                                input logic [31:0] i2, input logic [31:0] pc,
                                input logic st, input logic fl, input logic ev1,
                                input logic eiss, input logic efull, input int ecnt,
                                input logic [31:0] epc2);
        vec_t v;
        v.v1 = v1; v.v2 = v2; v.i1 = i1; v.i2 = i2; v.pc = pc; v.stall = st; v.flush = fl;
        v.e_v1 = ev1; v.e_iss = eiss; v.e_full = efull; v.e_cnt = (AW+1)'(ecnt); v.e_pc2 = epc2;
        return v;
    endfunction

    vec_t vecs[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Inputs are driven as: v1 v2 inst1 inst2 pc stall flush | valid1 issue full count pc2
        vecs[0]  = mk(1, 1, ADDU_A, ADDU_B, 32'hBFC0_0000, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[1]  = mk(0, 0, NOP, NOP, 32'h0, 0, 0, 1, DUAL, 0, 2, DUAL ? 32'hBFC0_0004 : 32'h0);
        vecs[2]  = mk(0, 0, NOP, NOP, 32'h0, 0, 0, !DUAL, 0, 0, DUAL ? 0 : 1, 32'h0);
        vecs[3]  = mk(0, 0, NOP, NOP, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[4]  = mk(1, 1, ADDIU1, ADDU_C, 32'h100, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[5]  = mk(0, 0, NOP, NOP, 32'h0, 0, 0, 1, 0, 0, 2, 32'h0);
        vecs[6]  = mk(0, 0, NOP, NOP, 32'h0, 1, 0, 1, 0, 0, 1, 32'h0);
        vecs[7]  = mk(0, 0, NOP, NOP, 32'h0, 0, 0, 1, 0, 0, 1, 32'h0);
        vecs[8]  = mk(1, 0, BEQ0, NOP, 32'h200, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[9]  = mk(1, 0, NOP, NOP, 32'h204, 0, 0, 0, 0, 0, 1, 32'h0);
        vecs[10] = mk(0, 0, NOP, NOP, 32'h0, 0, 0, 1, DUAL, 0, 2, DUAL ? 32'h204 : 32'h0);
        vecs[11] = mk(0, 0, NOP, NOP, 32'h0, 0, 0, !DUAL, 0, 0, DUAL ? 0 : 1, 32'h0);
        vecs[12] = mk(1, 1, ADDU_A, ADDU_B, 32'h300, 1, 0, 0, 0, 0, 0, 32'h0);
        vecs[13] = mk(1, 1, ADDU_A, ADDU_B, 32'h308, 1, 0, 1, DUAL, 0, 2, DUAL ? 32'h304 : 32'h0);
        vecs[14] = mk(1, 0, ADDU_A, NOP, 32'h310, 1, 0, 1, DUAL, 0, 4, DUAL ? 32'h304 : 32'h0);
        vecs[15] = mk(1, 1, ADDU_A, ADDU_B, 32'h318, 1, 1, 1, DUAL, 0, 5, DUAL ? 32'h304 : 32'h0);
        vecs[16] = mk(0, 0, NOP, NOP, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Reset: DUT state is unknown before the first edge, so nothing is compared yet.
        drive(1, 0, 0, NOP, NOP, 32'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        drive(0, 0, 0, NOP, NOP, 32'h0, 0, 0);
        sample();
        check("rst_count",  count_o,  0);
        check("rst_valid1", valid1_o, 0);
        check("rst_issue",  issue_o,  0);
        check("rst_full",   full_o,   0);
        check("rst_outs",   {inst1_o | inst2_o | pc1_o | pc2_o}, 0);
        advance();

        for (int k = 0; k < 17; k++) begin
            drive(0, vecs[k].v1, vecs[k].v2, vecs[k].i1, vecs[k].i2, vecs[k].pc,
                  vecs[k].stall, vecs[k].flush);
            sample();
            check($sformatf("tbl_valid1[%0d]", k), valid1_o, vecs[k].e_v1);
            check($sformatf("tbl_issue[%0d]", k),  issue_o,  vecs[k].e_iss);
            check($sformatf("tbl_full[%0d]", k),   full_o,   vecs[k].e_full);
            check($sformatf("tbl_count[%0d]", k),  count_o,  vecs[k].e_cnt);
            check($sformatf("tbl_pc2[%0d]", k),    pc2_o,    vecs[k].e_pc2);
            advance();
        end

        // Fill to the full threshold under stall, drop a push, then drain across the wrap.
        step(0, 1, 1, ADDU_A, ADDU_B, 32'h400, 1, 0);
        step(0, 1, 1, ADDU_A, ADDU_B, 32'h408, 1, 0);
        step(0, 1, 1, ADDU_A, ADDU_B, 32'h410, 1, 0);
        drive(0, 1, 0, ADDU_A, NOP, 32'h418, 1, 0);
        sample();
        check("fill_count6", count_o, 6);
        check("fill_full6",  full_o,  0);
        advance();
        drive(0, 1, 1, ADDU_A, ADDU_B, 32'h420, 1, 0);
        sample();
        check("fill_count7", count_o, 7);
        check("fill_full7",  full_o,  1);
        advance();
        drive(0, 0, 0, NOP, NOP, 32'h0, 1, 0);
        sample();
        check("fill_dropped", count_o, 7);
        advance();
        repeat (8) step(0, 0, 0, NOP, NOP, 32'h0, 0, 0);
        step(0, 1, 1, ADDIU1, ADDU_C, 32'h500, 0, 0);
        repeat (3) step(0, 0, 0, NOP, NOP, 32'h0, 0, 0);
        drive(0, 0, 0, NOP, NOP, 32'h0, 0, 0);
        sample();
        check("drain_count", count_o, 0);
        advance();

        // Reset has priority over a simultaneous push and flush.
        step(0, 1, 1, ADDU_A, ADDU_B, 32'h600, 1, 0);
        step(1, 1, 1, ADDU_A, ADDU_B, 32'h608, 0, 1);
        drive(0, 0, 0, NOP, NOP, 32'h0, 0, 0);
        sample();
        check("rst_mid_count",  count_o,  0);
        check("rst_mid_valid1", valid1_o, 0);
        advance();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic r, v1, v2, st, fl;
            r  = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 3) == 0);
            v1 = ($urandom_range(0, 3) != 0);
            v2 = v1 && ($urandom_range(0, 1) == 1);
            step(r, v1, v2, rand_inst(), rand_inst(), $urandom() & 32'hFFFF_FFFC, st, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_buffer.md
ISSUE_BUFFER -- requirements
Module: issue_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: entry count, power of two, 4..64.
REQ-002 SHALL have parameter AW, default $clog2(DEPTH): pointer width; count width is AW+1.
REQ-003 SHALL have clk  input  1  rising-edge clock.
REQ-004 SHALL have rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have flush_i  input  1  discard all entries (exception or redirect).
REQ-006 SHALL have stall_i  input  1  decode stall; no pop this cycle.
REQ-007 SHALL have fetch_valid1_i, fetch_valid2_i  input  1 each  fetch slot valid; slot2 is valid only with slot1.
REQ-008 SHALL have fetch_inst1_i, fetch_inst2_i  input  32 each  fetched words.
REQ-009 SHALL have fetch_pc_i  input  32  PC of slot1; slot2 PC is fetch_pc_i+4.
REQ-010 SHALL have full_o  output  1  fewer than 2 free entries; fetch must hold.
REQ-011 SHALL have inst1_o, inst2_o, pc1_o, pc2_o  output  32 each  head and head+1 entries.
REQ-012 SHALL have valid1_o  output  1  slot1 issues this cycle.
REQ-013 SHALL have issue_o  output  1  1 = dual issue, 0 = single issue; matches the decode-stage issue_i encoding.
REQ-014 SHALL have count_o  output  AW+1  occupied entries.

Function
REQ-015 SHALL circular-buffer entries of {inst, pc}, with head/tail pointers wrapping modulo DEPTH.
REQ-016 SHALL write push = fetch_valid1_i + fetch_valid2_i entries at tail in one cycle when full_o=0 and flush_i=0; push is ignored while full_o=1.
REQ-017 SHALL assert full_o combinationally from registered count: full_o = (DEPTH - count) < 2.
REQ-018 SHALL compute pop = 0 if stall_i, flush_i or valid1_o=0; otherwise 1 + issue_o.
REQ-019 SHALL update count_next = count + push - pop when push and pop happen in the same cycle.
REQ-020 SHALL present an entry on the outputs no earlier than the cycle after it is pushed, with no fall-through path.
REQ-021 SHALL set valid1_o = (count>=1), except when inst1 is a branch/jump and count==1; that case holds until the delay slot is buffered.
REQ-022 SHALL treat the following as branch/jump: J, JAL, BEQ, BNE, BLEZ, BGTZ, REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL, SPECIAL JR/JALR.
REQ-023 SHALL set issue_o=1 only when valid1_o=1, count>=2, and no blocker below applies.
REQ-024 SHALL treat as a blocker inst2 reading (rs, or rt for R-type/store/branch) a non-zero dest of inst1, where dest is rd for SPECIAL/SPECIAL2 MUL, 31 for JAL/xxxAL, and rt for I-type ALU, loads and MFC0.
REQ-025 SHALL treat as a blocker inst2 being a branch/jump, load/store/LL/SC, SPECIAL funct 0x10-0x1B (HI/LO, mult/div), SPECIAL2, or COP0.
REQ-026 SHALL treat as a blocker inst1 being COP0, ERET or SYSCALL/BREAK.
REQ-027 SHALL make flush_i empty the buffer next cycle, with count=0 and head=tail=0; flush_i overrides simultaneous push, pop and stall.
REQ-028 SHALL drive inst/pc outputs to 0 for slots that are not valid.

Reset
REQ-029 SHALL on rst clear head, tail and count to 0, giving valid1_o=0, issue_o=0, full_o=0, count_o=0, and all inst/pc outputs 0.
REQ-030 SHALL give rst priority over flush_i, push and pop; any entry mid-flight is discarded.

Configuration
REQ-031 SHALL, with IB_DUAL_ISSUE_EN defined, evaluate dual issue per REQ-023..026.
REQ-032 SHALL, without IB_DUAL_ISSUE_EN, tie issue_o to 0, limit pop to at most 1, and keep the REQ-021 delay-slot hold.

Verification
REQ-033 SHALL cover: reset, then push ADDU $1,$2,$3 and ADDU $4,$5,$6 at PC 0xBFC00000 -> next cycle valid1_o=1, issue_o=1, pc2_o=0xBFC00004, then count_o=0.
REQ-034 SHALL cover: push ADDIU $1,$0,5 then ADDU $2,$1,$1 -> issue_o=0, single pop, count_o 2->1.
REQ-035 SHALL cover: push BEQ alone -> valid1_o=0; next cycle push NOP -> valid1_o=1, issue_o=1.
REQ-036 SHALL cover: DEPTH=8, push 2/cycle with stall_i=1 -> full_o=1 at count_o=7 or 8; further pushes are dropped and the pointer wraps correctly after draining.
REQ-037 SHALL cover: count_o=5, flush_i with simultaneous push -> count_o=0 next cycle, valid1_o=0.
REQ-038 SHALL cover: IB_DUAL_ISSUE_EN undefined with an independent pair -> issue_o=0, two single pops over two cycles.
